// File: rtl/cia_serial_port.sv
// CIA 8520 serial data register engine: transmits buffered words on SP/CNT clocked by
// Timer A underflows (output mode) or receives words from external SP/CNT (input mode).
module cia_serial_port #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk7_en,
  input  logic              wr,
  input  logic              sdr,
  input  logic              spmode,
  input  logic              tmra_ovf,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              cnt_in,
  input  logic              sp_in,
  output logic              cnt_out,
  output logic              sp_out,
  output logic              cnt_oe,
  output logic              sp_oe,
  output logic              irq_ser
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]             state, state_nxt;
  logic [DATA_W-1:0]      buf_q, buf_nxt;
  logic                   buf_full, buf_full_nxt;
  logic [DATA_W-1:0]      shreg, shreg_nxt;
  logic [CNT_W-1:0]       bitcnt, bitcnt_nxt;
  logic [DATA_W-1:0]      rxlatch, rxlatch_nxt;
  logic                   cnt_out_nxt, sp_out_nxt, irq_nxt;
  logic [SYNC_STAGES-1:0] cnt_sync, sp_sync;
  logic                   cnt_prev, spmode_q;
  logic                   cnt_s, sp_s, cnt_rise, mode_chg, cpu_wr;

  assign cnt_s    = cnt_sync[SYNC_STAGES-1];
  assign sp_s     = sp_sync[SYNC_STAGES-1];
  assign cnt_rise = cnt_s & ~cnt_prev;
  assign mode_chg = spmode ^ spmode_q;
  assign cpu_wr   = wr & sdr;

  assign cnt_oe   = spmode;
  assign sp_oe    = spmode;
  assign data_out = (sdr & ~wr) ? (spmode ? buf_q : rxlatch) : '0;

  // Pin synchronisers; cnt_prev always follows the synchronised CNT so a mode change reseeds it.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        cnt_sync <= '1;
        sp_sync  <= '1;
        cnt_prev <= 1'b1;
        spmode_q <= spmode;
      end else begin
        cnt_sync <= {cnt_sync[SYNC_STAGES-2:0], cnt_in};
        sp_sync  <= {sp_sync[SYNC_STAGES-2:0], sp_in};
        cnt_prev <= cnt_s;
        spmode_q <= spmode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        state    <= IDLE;
        buf_q    <= '0;
        buf_full <= 1'b0;
        shreg    <= '0;
        bitcnt   <= '0;
        rxlatch  <= '0;
        cnt_out  <= 1'b1;
        sp_out   <= 1'b1;
        irq_ser  <= 1'b0;
      end else begin
        state    <= state_nxt;
        buf_q    <= buf_nxt;
        buf_full <= buf_full_nxt;
        shreg    <= shreg_nxt;
        bitcnt   <= bitcnt_nxt;
        rxlatch  <= rxlatch_nxt;
        cnt_out  <= cnt_out_nxt;
        sp_out   <= sp_out_nxt;
        irq_ser  <= irq_nxt;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    buf_nxt      = buf_q;
    buf_full_nxt = buf_full;
    shreg_nxt    = shreg;
    bitcnt_nxt   = bitcnt;
    rxlatch_nxt  = rxlatch;
    cnt_out_nxt  = cnt_out;
    sp_out_nxt   = sp_out;
    irq_nxt      = 1'b0;

    if (mode_chg) begin
      // Direction change drops whatever word was in flight.
      state_nxt    = IDLE;
      bitcnt_nxt   = '0;
      buf_full_nxt = 1'b0;
      cnt_out_nxt  = 1'b1;
      sp_out_nxt   = 1'b1;
    end else if (spmode) begin
      if (cpu_wr) begin
        buf_nxt      = data_in;
        buf_full_nxt = 1'b1;
      end
      case (state)
        IDLE: begin
          cnt_out_nxt = 1'b1;
          if (tmra_ovf && buf_full) begin
            // A write in the load cycle keeps the buffer full with the new word.
            shreg_nxt   = buf_q;
            if (!cpu_wr) buf_full_nxt = 1'b0;
            sp_out_nxt  = buf_q[DATA_W-1];
            cnt_out_nxt = 1'b0;
            bitcnt_nxt  = CNT_W'(DATA_W);
            state_nxt   = SHIFT;
          end
        end
        default: begin
          if (tmra_ovf) begin
            if (!cnt_out) begin
              cnt_out_nxt = 1'b1;
              bitcnt_nxt  = bitcnt - CNT_W'(1);
              if (bitcnt == CNT_W'(1)) begin
                irq_nxt   = 1'b1;
                state_nxt = IDLE;
              end
            end else begin
              cnt_out_nxt = 1'b0;
              shreg_nxt   = shreg << 1;
              sp_out_nxt  = shreg[DATA_W-2];
            end
          end
        end
      endcase
    end else begin
      cnt_out_nxt = 1'b1;
      sp_out_nxt  = 1'b1;
      if (cpu_wr) rxlatch_nxt = data_in;
      if (bitcnt == CNT_W'(DATA_W)) begin
        rxlatch_nxt = shreg;
        irq_nxt     = 1'b1;
        bitcnt_nxt  = '0;
      end
      if (cnt_rise) begin
        shreg_nxt  = {shreg[DATA_W-2:0], sp_s};
        bitcnt_nxt = bitcnt_nxt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cia_serial_port.sv
// Scoreboard bench for cia_serial_port: an SP/CNT receiver model collects transmitted
// words and irq_ser timing, compared against expectations queued at stimulus time.
module tb_cia_serial_port;

  logic        clk = 1'b0;
  logic        reset, clk7_en, wr, sdr, spmode, tmra_ovf, cnt_in, sp_in;
  logic [7:0]  data_in;
  logic [15:0] data_in16;
  logic [7:0]  data_out;
  logic [15:0] data_out16;
  logic        cnt_out, sp_out, cnt_oe, sp_oe, irq_ser;
  logic        cnt_out16, sp_out16, cnt_oe16, sp_oe16, irq_ser16;

  int n_vec = 0;
  int n_err = 0;

  cia_serial_port #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .sdr(sdr), .spmode(spmode),
    .tmra_ovf(tmra_ovf), .data_in(data_in), .data_out(data_out), .cnt_in(cnt_in),
    .sp_in(sp_in), .cnt_out(cnt_out), .sp_out(sp_out), .cnt_oe(cnt_oe), .sp_oe(sp_oe),
    .irq_ser(irq_ser));

  cia_serial_port #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .sdr(sdr), .spmode(spmode),
    .tmra_ovf(tmra_ovf), .data_in(data_in16), .data_out(data_out16), .cnt_in(cnt_in),
    .sp_in(sp_in), .cnt_out(cnt_out16), .sp_out(sp_out16), .cnt_oe(cnt_oe16), .sp_oe(sp_oe16),
    .irq_ser(irq_ser16));

  always #5 clk = ~clk;

  // Receiver model and event recorders
  int         ovf_cnt = 0, irq_cnt = 0, irq16_cnt = 0, fall_cnt = 0;
  int         irq_q[$], irq16_q[$];
  logic [7:0] got_q[$], exp_q[$];
  logic [15:0] got16_q[$], exp16_q[$];
  logic [7:0] rx_w = '0;
  logic [15:0] rx16_w = '0;
  int         rx_n = 0, rx16_n = 0;
  logic       cnt_prev = 1'b1, cnt16_prev = 1'b1;

  always @(negedge clk) begin
    if (irq_ser) begin irq_cnt++; irq_q.push_back(ovf_cnt); end
    if (irq_ser16) begin irq16_cnt++; irq16_q.push_back(ovf_cnt); end
    if (clk7_en && tmra_ovf) ovf_cnt++;
    if (reset || !spmode) begin
      rx_n = 0;
      rx16_n = 0;
    end else begin
      if (cnt_out && !cnt_prev) begin
        rx_w = {rx_w[6:0], sp_out};
        rx_n++;
        if (rx_n == 8) begin got_q.push_back(rx_w); rx_n = 0; end
      end
      if (!cnt_out && cnt_prev) fall_cnt++;
      if (cnt_out16 && !cnt16_prev) begin
        rx16_w = {rx16_w[14:0], sp_out16};
        rx16_n++;
        if (rx16_n == 16) begin got16_q.push_back(rx16_w); rx16_n = 0; end
      end
    end
    cnt_prev = cnt_out;
    cnt16_prev = cnt_out16;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ovf(input int n);
    repeat (n) begin tmra_ovf = 1'b1; cyc(1); tmra_ovf = 1'b0; cyc(3); end
  endtask

  task automatic cpu_write(input logic [7:0] d8, input logic [15:0] d16);
    wr = 1'b1; sdr = 1'b1; data_in = d8; data_in16 = d16;
    cyc(1);
    wr = 1'b0; sdr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
  endtask

  task automatic send_in_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      sp_in = w[i]; cnt_in = 1'b0; cyc(4);
      cnt_in = 1'b1; cyc(4);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    spmode = 1'b0;
    do_reset();
    @(negedge clk);
    n_vec++; if (cnt_out !== 1'b1) begin n_err++; $display("FAIL reset_cnt_out got=%b want=1", cnt_out); end
    n_vec++; if (sp_out !== 1'b1) begin n_err++; $display("FAIL reset_sp_out got=%b want=1", sp_out); end
    n_vec++; if (irq_ser !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", irq_ser); end
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out got=%h want=00", data_out); end
    n_vec++; if (cnt_oe !== 1'b0 || sp_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe_in got=%b%b want=00", cnt_oe, sp_oe); end
    sdr = 1'b1;
    @(negedge clk); rd = data_out;
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL reset_rxlatch got=%h want=00", rd); end
    sdr = 1'b0;
    spmode = 1'b1;
    @(negedge clk);
    n_vec++; if (cnt_oe !== 1'b1 || sp_oe !== 1'b1) begin n_err++; $display("FAIL reset_oe_out got=%b%b want=11", cnt_oe, sp_oe); end
    @(posedge clk); #1; cyc(2);
  endtask

  task automatic test_single_word();
    int base, i0;
    got_q.delete(); irq_q.delete(); exp_q.delete();
    i0 = irq_cnt;
    cpu_write(8'hA5, 16'h0000);
    exp_q.push_back(8'hA5);
    sdr = 1'b1;
    @(negedge clk);
    n_vec++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL single_readback got=%h want=a5", data_out); end
    sdr = 1'b0;
    @(posedge clk); #1;
    // underflow while clk7_en is low must not load
    clk7_en = 1'b0; tmra_ovf = 1'b1; cyc(1); tmra_ovf = 1'b0; clk7_en = 1'b1; cyc(1);
    @(negedge clk);
    n_vec++; if (cnt_out !== 1'b1) begin n_err++; $display("FAIL single_gated_ovf cnt_out got=%b want=1", cnt_out); end
    @(posedge clk); #1;
    base = ovf_cnt;
    ovf(16); cyc(3);
    n_vec++; if (irq_cnt - i0 !== 1) begin n_err++; $display("FAIL single_irq_count got=%0d want=1", irq_cnt - i0); end
    n_vec++;
    if (irq_q.size() == 0) begin n_err++; $display("FAIL single_irq_time got=none want=%0d", base + 16); end
    else begin
      int t = irq_q.pop_front();
      if (t !== base + 16) begin n_err++; $display("FAIL single_irq_time got=%0d want=%0d", t, base + 16); end
    end
    n_vec++;
    if (got_q.size() == 0) begin n_err++; $display("FAIL single_word got=none want=%h", exp_q[0]); end
    else begin
      logic [7:0] g = got_q.pop_front(), e = exp_q.pop_front();
      if (g !== e) begin n_err++; $display("FAIL single_word got=%h want=%h", g, e); end
    end
    @(negedge clk);
    n_vec++; if (cnt_out !== 1'b1) begin n_err++; $display("FAIL single_cnt_idle got=%b want=1", cnt_out); end
    @(posedge clk); #1;
  endtask

  // Shared checker for two-word streams: irqs 16 underflows apart, words in order.
  task automatic test_back_to_back();
    int base, i0;
    got_q.delete(); irq_q.delete(); exp_q.delete();
    i0 = irq_cnt;
    cpu_write(8'h81, 16'h0000); exp_q.push_back(8'h81);
    base = ovf_cnt;
    ovf(3);
    cpu_write(8'h7E, 16'h0000); exp_q.push_back(8'h7E);
    ovf(29); cyc(3);
    n_vec++; if (irq_cnt - i0 !== 2) begin n_err++; $display("FAIL b2b_irq_count got=%0d want=2", irq_cnt - i0); end
    for (int k = 1; k <= 2; k++) begin
      n_vec++;
      if (irq_q.size() == 0) begin n_err++; $display("FAIL b2b_irq_time%0d got=none want=%0d", k, base + 16*k); end
      else begin
        int t = irq_q.pop_front();
        if (t !== base + 16*k) begin n_err++; $display("FAIL b2b_irq_time%0d got=%0d want=%0d", k, t, base + 16*k); end
      end
      n_vec++;
      if (got_q.size() == 0) begin n_err++; $display("FAIL b2b_word%0d got=none want=%h", k, exp_q[0]); void'(exp_q.pop_front()); end
      else begin
        logic [7:0] g = got_q.pop_front(), e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL b2b_word%0d got=%h want=%h", k, g, e); end
      end
    end
  endtask

  task automatic test_coincident();
    int base, i0;
    got_q.delete(); irq_q.delete(); exp_q.delete();
    i0 = irq_cnt;
    cpu_write(8'h11, 16'h0000); exp_q.push_back(8'h11);
    cyc(1);
    base = ovf_cnt;
    tmra_ovf = 1'b1; wr = 1'b1; sdr = 1'b1; data_in = 8'h22; exp_q.push_back(8'h22);
    cyc(1);
    tmra_ovf = 1'b0; wr = 1'b0; sdr = 1'b0;
    cyc(3);
    ovf(31); cyc(3);
    n_vec++; if (irq_cnt - i0 !== 2) begin n_err++; $display("FAIL coinc_irq_count got=%0d want=2", irq_cnt - i0); end
    for (int k = 1; k <= 2; k++) begin
      n_vec++;
      if (irq_q.size() == 0) begin n_err++; $display("FAIL coinc_irq_time%0d got=none want=%0d", k, base + 16*k); end
      else begin
        int t = irq_q.pop_front();
        if (t !== base + 16*k) begin n_err++; $display("FAIL coinc_irq_time%0d got=%0d want=%0d", k, t, base + 16*k); end
      end
      n_vec++;
      if (got_q.size() == 0) begin n_err++; $display("FAIL coinc_word%0d got=none want=%h", k, exp_q[0]); void'(exp_q.pop_front()); end
      else begin
        logic [7:0] g = got_q.pop_front(), e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL coinc_word%0d got=%h want=%h", k, g, e); end
      end
    end
  endtask

  task automatic recv_and_check(input logic [7:0] w, input string tag);
    int i0, waited;
    logic [7:0] e;
    exp_q.delete();
    i0 = irq_cnt;
    send_in_word(w); exp_q.push_back(w);
    waited = 0;
    while (irq_cnt == i0 && waited < 20) begin cyc(1); waited++; end
    cyc(2);
    n_vec++; if (irq_cnt - i0 !== 1) begin n_err++; $display("FAIL %s_irq_count got=%0d want=1", tag, irq_cnt - i0); end
    e = exp_q.pop_front();
    sdr = 1'b1;
    @(negedge clk);
    n_vec++; if (data_out !== e) begin n_err++; $display("FAIL %s_readback got=%h want=%h", tag, data_out, e); end
    sdr = 1'b0;
    @(negedge clk);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL %s_orbus_idle got=%h want=00", tag, data_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_input_receive();
    spmode = 1'b0; cnt_in = 1'b1; sp_in = 1'b1;
    cyc(4);
    recv_and_check(8'h3C, "rx");
    @(negedge clk);
    n_vec++; if (cnt_out !== 1'b1 || sp_out !== 1'b1) begin n_err++; $display("FAIL rx_pins got=%b%b want=11", cnt_out, sp_out); end
    n_vec++; if (cnt_oe !== 1'b0) begin n_err++; $display("FAIL rx_cnt_oe got=%b want=0", cnt_oe); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int i0, f0;
    spmode = 1'b1; cyc(3);
    i0 = irq_cnt;
    cpu_write(8'hFF, 16'h0000);
    ovf(5);
    spmode = 1'b0;
    cyc(4);
    @(negedge clk);
    n_vec++; if (irq_cnt - i0 !== 0) begin n_err++; $display("FAIL abort_irq got=%0d want=0", irq_cnt - i0); end
    n_vec++; if (cnt_out !== 1'b1 || sp_out !== 1'b1) begin n_err++; $display("FAIL abort_pins got=%b%b want=11", cnt_out, sp_out); end
    @(posedge clk); #1;
    recv_and_check(8'hA6, "abort_rx");
    spmode = 1'b1; cyc(3);
    i0 = irq_cnt; f0 = fall_cnt;
    ovf(4); cyc(2);
    n_vec++; if (fall_cnt - f0 !== 0) begin n_err++; $display("FAIL abort_buf_empty falls=%0d want=0", fall_cnt - f0); end
    n_vec++; if (irq_cnt - i0 !== 0) begin n_err++; $display("FAIL abort_no_irq got=%0d want=0", irq_cnt - i0); end
  endtask

  task automatic test_reset_mid_word();
    int i0, f0;
    i0 = irq_cnt;
    cpu_write(8'h5A, 16'h0000);
    ovf(5);
    do_reset();
    @(negedge clk);
    n_vec++; if (cnt_out !== 1'b1 || sp_out !== 1'b1 || irq_ser !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs got=%b%b%b want=110", cnt_out, sp_out, irq_ser); end
    sdr = 1'b1;
    @(negedge clk);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL midrst_buf got=%h want=00", data_out); end
    sdr = 1'b0;
    @(posedge clk); #1;
    f0 = fall_cnt;
    ovf(20); cyc(2);
    n_vec++; if (irq_cnt - i0 !== 0) begin n_err++; $display("FAIL midrst_irq got=%0d want=0", irq_cnt - i0); end
    n_vec++; if (fall_cnt - f0 !== 0) begin n_err++; $display("FAIL midrst_idle falls=%0d want=0", fall_cnt - f0); end
  endtask

  task automatic test_wide();
    int base, i0;
    do_reset();
    got16_q.delete(); irq16_q.delete(); exp16_q.delete();
    i0 = irq16_cnt;
    cpu_write(8'h00, 16'hA5C3); exp16_q.push_back(16'hA5C3);
    base = ovf_cnt;
    ovf(32); cyc(3);
    n_vec++; if (irq16_cnt - i0 !== 1) begin n_err++; $display("FAIL wide_irq_count got=%0d want=1", irq16_cnt - i0); end
    n_vec++;
    if (irq16_q.size() == 0) begin n_err++; $display("FAIL wide_irq_time got=none want=%0d", base + 32); end
    else begin
      int t = irq16_q.pop_front();
      if (t !== base + 32) begin n_err++; $display("FAIL wide_irq_time got=%0d want=%0d", t, base + 32); end
    end
    n_vec++;
    if (got16_q.size() == 0) begin n_err++; $display("FAIL wide_word got=none want=%h", exp16_q[0]); end
    else begin
      logic [15:0] g = got16_q.pop_front(), e = exp16_q.pop_front();
      if (g !== e) begin n_err++; $display("FAIL wide_word got=%h want=%h", g, e); end
    end
  endtask

  initial begin
    reset = 1'b1; clk7_en = 1'b1; wr = 1'b0; sdr = 1'b0; spmode = 1'b0; tmra_ovf = 1'b0;
    cnt_in = 1'b1; sp_in = 1'b1; data_in = '0; data_in16 = '0;
    cyc(2);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_coincident();
    test_input_receive();
    test_abort();
    test_reset_mid_word();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cia_serial_port.md
# cia_serial_port

Parametrised CIA serial data register (SDR) engine for the 8520 CIA blocks, replacing the inert write/readback SDR latch. Operates in both 8520 directions:
- **Output mode:** shifts buffered words out on SP/CNT, clocked by Timer A underflows.
- **Input mode:** shifts words in from external SP/CNT.

It sits beside the timer and interrupt submodules and drives the `ser` input of the interrupt controller. Data width and input synchroniser depth are generalised.

## Interface
Parameters:
- `DATA_W`, 8, shift/buffer width in bits (≥2).
- `SYNC_STAGES`, 2, synchroniser flops on `cnt_in`/`sp_in` (≥2).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. Sampled on `clk` edges with `clk7_en` high.
- `clk7_en`  in  1  7 MHz enable. All state updates only when high.
- `wr`  in  1  CPU write strobe.
- `sdr`  in  1  SDR register select, already qualified with `aen & (rd|wr)`.
- `spmode`  in  1  CRA bit 6. 1 = output, 0 = input.
- `tmra_ovf`  in  1  Timer A underflow strobe.
- `data_in`  in  `DATA_W`  CPU write data.
- `data_out`  out  `DATA_W`  readback. Zero unless `sdr & ~wr` (OR-bus).
- `cnt_in`  in  1  external CNT pin.
- `sp_in`  in  1  external SP pin.
- `cnt_out`  out  1  CNT drive value.
- `sp_out`  out  1  SP drive value.
- `cnt_oe`  out  1  CNT output enable, equals `spmode`.
- `sp_oe`  out  1  SP output enable, equals `spmode`.
- `irq_ser`  out  1  one-`clk7_en`-cycle pulse per completed word. Drives `cia_int.ser`.

## Operation
Registers:
- `buf` (`DATA_W`)
- `buf_full`
- `shreg` (`DATA_W`)
- `bitcnt` (`0..DATA_W`)
- `rxlatch` (`DATA_W`)
- state: `IDLE` / `SHIFT`

Output mode (`spmode=1`):
- **Write** (`wr & sdr`): `buf<=data_in`, `buf_full<=1`.
- **IDLE:** `cnt_out=1`.
- **Load** (IDLE, `tmra_ovf & buf_full`):
  - `shreg<=buf`, `buf_full<=0`.
  - `sp_out<=buf[DATA_W-1]` (MSB first).
  - `cnt_out<=0`, `bitcnt<=DATA_W`, go to SHIFT.
- **SHIFT, on `tmra_ovf`:**
  - If `cnt_out=0`: `cnt_out<=1` (receiver samples on this rising edge) and `bitcnt<=bitcnt-1`.
    - If `bitcnt` was 1: pulse `irq_ser` and go to IDLE.
  - Else (`cnt_out=1`): `cnt_out<=0`, `shreg<=shreg<<1`, `sp_out<=shreg[DATA_W-2]`.
- **Back-to-back:** with `buf_full` set, the next underflow after returning to IDLE loads the next word. The stream has uniform 2-underflow bit cells and no gap.
- **Readback:** `data_out=buf`.

Input mode (`spmode=0`):
- `cnt_in`/`sp_in` pass through `SYNC_STAGES` flops.
- On a synchronised CNT rising edge: `shreg<={shreg[DATA_W-2:0], sp_sync}`, `bitcnt<=bitcnt+1`.
- When `bitcnt` reaches `DATA_W`: `rxlatch<=` completed word, `irq_ser` pulse, `bitcnt<=0`.
- **Write** (`wr & sdr`): `rxlatch<=data_in`. Starts nothing.
- **Readback:** `data_out=rxlatch`.
- `cnt_out=1`, `sp_out=1` while in input mode.

Boundary rules:
- **Write while `buf_full`:** overwrites `buf`. No overrun flag.
- **Write coincident with load:** `shreg` takes the old `buf`, `buf` takes `data_in`, and `buf_full` ends at 1.
- **`spmode` change (either direction):** aborts the current word. `bitcnt<=0`, state IDLE, `buf_full<=0`, `cnt_out<=1`, `sp_out<=1`, no `irq_ser`. CNT edge detector is reseeded from the current synchronised value, so no spurious edge.
- **`tmra_ovf` without `clk7_en`:** ignored.
- **Reset mid-shift:** the word is dropped and no `irq_ser` is issued.

## Timing
- **Reset values:**
  - `cnt_out=1`, `sp_out=1`, `irq_ser=0`.
  - `data_out=0` (no read in progress).
  - `buf`, `shreg`, `rxlatch` = 0; `buf_full=0`; `bitcnt=0`; IDLE.
  - `cnt_oe`/`sp_oe` follow `spmode`.
- **Output, write to load:** the first `tmra_ovf` strictly after the write's `clk7_en` cycle.
- **Output, load to `irq_ser`:** exactly `2*DATA_W` underflows, inclusive of the load underflow. `irq_ser` is asserted in the `clk7_en` cycle after the final underflow is registered.
- **Input, CNT edge to shift:** `SYNC_STAGES+1` enabled cycles from the pin edge.
- **Input, last edge to `irq_ser`:** `irq_ser` and `rxlatch` update in the same cycle, one enabled cycle after the final shift.
- **`data_out`:** combinational from registers. Valid in the same cycle as `sdr & ~wr`.

## Test plan
- **Single output word:** `DATA_W=8`, `spmode=1`, write `8'hA5`, `tmra_ovf` every 4 enabled cycles → SP bits 1,0,1,0,0,1,0,1 sampled at 8 CNT rising edges; exactly one `irq_ser` after the 16th underflow; `cnt_out=1` after.
- **Back-to-back:** write `8'h81`, then `8'h7E` while shifting → 16 contiguous bit cells; two `irq_ser` pulses exactly 16 underflows apart; no idle cell between words.
- **Input receive:** `spmode=0`, drive CNT at 1/8 clk rate with SP pattern `0x3C` MSB first → `rxlatch=0x3C`, one `irq_ser`; reading SDR returns `8'h3C`.
- **Abort:** toggle `spmode` 1→0 after 5 underflows of `8'hFF` → no `irq_ser`; `cnt_out=1`; `buf_full=0`; a subsequent 8-bit input word is received correctly.
- **Coincident write/load:** `buf=8'h11` full; write `8'h22` in the same cycle as the load underflow → `8'h11` transmitted, then `8'h22`.
- **Reset and parametrisation:** assert `reset` mid-word → all outputs at reset values, no irq. Repeat the first scenario with `DATA_W=16` → `irq_ser` after 32 underflows.
